// File: rtl/bcd_digit_scanner_if.sv
// Bundles the upstream digit-load controls and the decoder-side scan outputs
// of the multiplexed BCD display scanner.
interface bcd_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    // load is a single-cycle strobe with no back-pressure: digits_in is taken
    // on every edge where load=1; pending stays high until that data is shown.
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    blank_lz;
    logic [3:0]              bcd;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output digits_in, load, blank_lz,
        input  bcd, dig_en, pending, frame_tick
    );

    modport slave (
        input  digits_in, load, blank_lz,
        output bcd, dig_en, pending, frame_tick
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Scans NUM_DIGITS packed BCD digits onto one shared 7-segment decoder with
// tear-free frame updates, per-slot dead time and optional leading-zero blanking.
module bcd_digit_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_digit_scanner_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         display_q, display_d;
    logic                  pending_q, pending_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  presc_end;
    logic                  frame_wrap;
    logic                  dead;
    logic [3:0]            sel_digit;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  all_zero;

    always_comb begin
        presc_end  = (presc_q == PW'(REFRESH_DIV - 1));
        frame_wrap = presc_end && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d    = presc_end ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        if (presc_end) begin
            idx_d = frame_wrap ? '0 : idx_q + IW'(1);
        end
    end

    // A load on the wrap edge still lets the old shadow reach the display;
    // the new data then waits a full frame with pending held high.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (frame_wrap && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = bus.digits_in;
            pending_d = 1'b1;
        end
    end

    // lz_blank[i] is set when digit i and every more significant digit are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (display_d[4*i +: 4] == 4'h0);
            lz_blank[i] = all_zero;
        end
    end

    // Outputs are computed from the next-state values so the registered
    // outputs line up with the idx/prescaler they describe.
    always_comb begin
        sel_digit    = display_d[4*int'(idx_d) +: 4];
        dead         = (int'(presc_d) < BLANK_CYC);
        dig_en_d     = '0;
        bcd_d        = 4'hF;
        frame_tick_d = frame_wrap;
        if (!dead) begin
            dig_en_d = NUM_DIGITS'(1) << idx_d;
            if (!(bus.blank_lz && lz_blank[idx_d])) begin
                bcd_d = sel_digit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            bcd_q        <= 4'hF;
            dig_en_q     <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner: table of load/blanking vectors checked
// slot by slot, plus sequences for tear-free update, coincident load and async reset.
module tb_bcd_digit_scanner;
    localparam int ND = 4;

    logic clk;
    logic rst_n;

    bcd_digit_scanner_if #(.NUM_DIGITS(ND)) bus();

    bcd_digit_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(4),
        .BLANK_CYC  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [15:0] digits;
        logic        lz;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d);
        bus.load      = 1'b1;
        bus.digits_in = d;
        @(negedge clk);
        bus.load = 1'b0;
        chk("pending_set", bus.pending, 1);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_tick && n < 40);
        chk("tick_seen", bus.frame_tick, 1);
    endtask

    // Entered at the sample where frame_tick is high; leaves at the next one.
    task automatic check_frame(input logic [15:0] exp);
        logic [3:0] e;
        for (int s = 0; s < ND; s++) exp_q.push_back(exp[4*s +: 4]);
        for (int s = 0; s < ND; s++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                chk("frame_tick", bus.frame_tick, (s == 0 && c == 0));
                if (c == 0) begin
                    chk("dead_en", bus.dig_en, 0);
                    chk("dead_bcd", bus.bcd, 4'hF);
                end else begin
                    chk("lit_en", bus.dig_en, 32'd1 << s);
                    chk("lit_bcd", bus.bcd, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_bcd", bus.bcd, 4'hF);
        chk("rst_en", bus.dig_en, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_tick", bus.frame_tick, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] old;
        int          slot;
        int          n;

        vecs[0] = '{16'h0070, 1'b1, 16'hFF70};
        vecs[1] = '{16'h0000, 1'b1, 16'hFFF0};
        vecs[2] = '{16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{16'h0A05, 1'b1, 16'hFA05};
        vecs[4] = '{16'h1000, 1'b1, 16'h1000};
        vecs[5] = '{16'h0070, 1'b0, 16'h0070};
        vecs[6] = '{16'h1234, 1'b0, 16'h1234};

        // Reset, with load held high to show it is ignored.
        rst_n         = 1'b1;
        bus.load      = 1'b0;
        bus.blank_lz  = 1'b0;
        bus.digits_in = 16'h0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        bus.load      = 1'b1;
        bus.digits_in = 16'hABCD;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        check_reset_vals();
        @(negedge clk);
        chk("first_en", bus.dig_en, 4'b0001);
        chk("first_bcd", bus.bcd, 4'h0);
        wait_tick();
        check_frame(16'h0000);

        for (int v = 0; v < 7; v++) begin
            bus.blank_lz = vecs[v].lz;
            pulse_load(vecs[v].digits);
            wait_tick();
            chk("pending_clr", bus.pending, 0);
            check_frame(vecs[v].exp);
        end

        // Tear-free update: mid-frame load keeps showing 1234 until the wrap.
        old = 16'h1234;
        repeat (5) @(negedge clk);
        pulse_load(16'h5678);
        n = 0;
        while (!bus.frame_tick && n < 20) begin
            if (bus.dig_en != 0) begin
                slot = 0;
                for (int i = 0; i < ND; i++) if (bus.dig_en[i]) slot = i;
                chk("tearfree_old", bus.bcd, old[4*slot +: 4]);
                chk("tearfree_pend", bus.pending, 1);
            end
            @(negedge clk);
            n++;
        end
        chk("tearfree_tick", bus.frame_tick, 1);
        chk("tearfree_clr", bus.pending, 0);
        check_frame(16'h5678);

        // Coincident load: 4321 pending, 9999 loaded on the wrap edge.
        bus.load      = 1'b1;
        bus.digits_in = 16'h4321;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (14) @(negedge clk);
        bus.load      = 1'b1;
        bus.digits_in = 16'h9999;
        @(negedge clk);
        bus.load = 1'b0;
        chk("coinc_tick", bus.frame_tick, 1);
        chk("coinc_pend", bus.pending, 1);
        check_frame(16'h4321);
        chk("coinc_clr", bus.pending, 0);
        check_frame(16'h9999);

        // Async reset in slot 2 with data pending.
        bus.load      = 1'b1;
        bus.digits_in = 16'h2468;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_en", bus.dig_en, 4'b0100);
        chk("pre_rst_bcd", bus.bcd, 4'h9);
        chk("pre_rst_pend", bus.pending, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        bus.load = 1'b1;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        check_reset_vals();
        @(negedge clk);
        chk("restart_en", bus.dig_en, 4'b0001);
        chk("restart_bcd", bus.bcd, 4'h0);
        wait_tick();
        check_frame(16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
